// File: rtl/uart_tx_fifo.sv
// UART transmitter with an internal push FIFO. The frame format (5-9 data bits, parity
// mode, 1/2 stop bits) is latched when a word is popped. Bits are paced by the i_stick tick.
module uart_tx_fifo #(
  parameter int DATA_MAX      = 9,
  parameter int OVER_SAMPLING = 16,
  parameter int FIFO_DEPTH    = 8
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_stick,
  input  logic                          i_valid,
  output logic                          o_ready,
  input  logic [DATA_MAX-1:0]           i_data,
  input  logic [2:0]                    i_size_frame,
  input  logic [2:0]                    i_parity,
  input  logic                          i_stop_bit,
  input  logic                          i_break,
  output logic                          o_data_tx,
  output logic                          o_done_tx,
  output logic                          o_busy,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count,
  output logic                          o_fifo_full,
  output logic                          o_fifo_empty
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(OVER_SAMPLING);
  localparam logic [AW:0]   DEPTH_C   = (AW+1)'(FIFO_DEPTH);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVER_SAMPLING - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2, S_DONE, S_BREAK, S_BRK_END
  } state_t;

  // FIFO storage and pointers
  logic [DATA_MAX-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [AW:0]         count_q;
  logic                push, pop;

  // Frame engine state
  state_t              state_q, state_d;
  logic [TW-1:0]       tick_q, tick_d;
  logic [3:0]          bit_idx_q, bit_idx_d;
  logic [3:0]          nbits_q, nbits_d;
  logic [DATA_MAX-1:0] shift_q, shift_d;
  logic                par_en_q, par_en_d;
  logic                par_bit_q, par_bit_d;
  logic                stop2_q, stop2_d;
  logic                tx_q, tx_d;

  // Format decode of the word at the FIFO head, used only at pop
  logic [DATA_MAX-1:0] head_word, head_masked;
  logic [3:0]          size_dec;
  logic                par_en_dec, par_bit_dec;
  logic                timed, bit_end;

  assign o_fifo_empty = (count_q == '0);
  assign o_fifo_full  = (count_q == DEPTH_C);
  assign o_ready      = ~o_fifo_full;
  assign o_fifo_count = count_q;
  assign push         = i_valid & o_ready;
  assign head_word    = mem_q[rd_ptr_q];

  // NOTE: the storage array has no reset; only pointers and count need defined values.
  always_ff @(posedge i_clk) begin
    if (push) mem_q[wr_ptr_q] <= i_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    size_dec    = 4'd8;
    par_en_dec  = 1'b0;
    par_bit_dec = 1'b0;
    head_masked = '0;
    case (i_size_frame)
      3'b000:  size_dec = 4'd5;
      3'b001:  size_dec = 4'd6;
      3'b010:  size_dec = 4'd7;
      3'b011:  size_dec = 4'd8;
      3'b100:  size_dec = 4'd9;
      default: size_dec = 4'd8;
    endcase
    for (int i = 0; i < DATA_MAX; i++) begin
      if (i < int'(size_dec)) head_masked[i] = head_word[i];
    end
    case (i_parity)
      3'b001:  begin par_en_dec = 1'b1; par_bit_dec = ~^head_masked; end
      3'b010:  begin par_en_dec = 1'b1; par_bit_dec = ^head_masked;  end
      3'b011:  begin par_en_dec = 1'b1; par_bit_dec = 1'b1;          end
      3'b100:  begin par_en_dec = 1'b1; par_bit_dec = 1'b0;          end
      default: begin par_en_dec = 1'b0; par_bit_dec = 1'b0;          end
    endcase
  end

  assign timed   = state_q inside {S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2, S_BRK_END};
  assign bit_end = timed && i_stick && (tick_q == TICK_LAST);

  always_comb begin
    state_d   = state_q;
    bit_idx_d = bit_idx_q;
    nbits_d   = nbits_q;
    shift_d   = shift_q;
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
    stop2_d   = stop2_q;
    tx_d      = tx_q;
    pop       = 1'b0;
    tick_d    = '0;
    if (timed) tick_d = bit_end ? '0 : (i_stick ? tick_q + TW'(1) : tick_q);

    // tx_d always carries the line level of the state being entered
    case (state_q)
      S_IDLE: begin
        if (i_break) begin
          state_d = S_BREAK;
          tx_d    = 1'b0;
        end else if (!o_fifo_empty) begin
          pop       = 1'b1;
          shift_d   = head_word;
          nbits_d   = size_dec;
          par_en_d  = par_en_dec;
          par_bit_d = par_bit_dec;
          stop2_d   = i_stop_bit;
          bit_idx_d = '0;
          state_d   = S_START;
          tx_d      = 1'b0;
        end
      end
      S_START: if (bit_end) begin
        state_d = S_DATA;
        tx_d    = shift_q[0];
      end
      S_DATA: if (bit_end) begin
        if (bit_idx_q == nbits_q - 4'd1) begin
          state_d = par_en_q ? S_PARITY : S_STOP1;
          tx_d    = par_en_q ? par_bit_q : 1'b1;
        end else begin
          bit_idx_d = bit_idx_q + 4'd1;
          shift_d   = shift_q >> 1;
          tx_d      = shift_q[1];
        end
      end
      S_PARITY: if (bit_end) begin
        state_d = S_STOP1;
        tx_d    = 1'b1;
      end
      S_STOP1: if (bit_end) begin
        state_d = stop2_q ? S_STOP2 : S_DONE;
        tx_d    = 1'b1;
      end
      S_STOP2: if (bit_end) begin
        state_d = S_DONE;
        tx_d    = 1'b1;
      end
      S_DONE: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
      end
      S_BREAK: begin
        state_d = i_break ? S_BREAK : S_BRK_END;
        tx_d    = ~i_break;
      end
      S_BRK_END: if (bit_end) begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      tick_q    <= '0;
      bit_idx_q <= '0;
      nbits_q   <= 4'd8;
      shift_q   <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      stop2_q   <= 1'b0;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      bit_idx_q <= bit_idx_d;
      nbits_q   <= nbits_d;
      shift_q   <= shift_d;
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
      stop2_q   <= stop2_d;
      tx_q      <= tx_d;
    end
  end

  assign o_data_tx = tx_q;
  assign o_done_tx = (state_q == S_DONE);
  assign o_busy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: pushed words queue their expected frame, and a
// line monitor decodes each frame by counting i_stick ticks and compares it.
module tb_uart_tx_fifo;

  localparam int DATA_MAX = 9;
  localparam int OS       = 16;
  localparam int DEPTH    = 8;

  logic       i_clk = 1'b0;
  logic       i_rst, i_stick, i_valid, i_stop_bit, i_break;
  logic [8:0] i_data;
  logic [2:0] i_size_frame, i_parity;
  logic       o_ready, o_data_tx, o_done_tx, o_busy, o_fifo_full, o_fifo_empty;
  logic [3:0] o_fifo_count;

  uart_tx_fifo #(.DATA_MAX(DATA_MAX), .OVER_SAMPLING(OS), .FIFO_DEPTH(DEPTH)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_stick(i_stick), .i_valid(i_valid), .o_ready(o_ready),
    .i_data(i_data), .i_size_frame(i_size_frame), .i_parity(i_parity),
    .i_stop_bit(i_stop_bit), .i_break(i_break), .o_data_tx(o_data_tx),
    .o_done_tx(o_done_tx), .o_busy(o_busy), .o_fifo_count(o_fifo_count),
    .o_fifo_full(o_fifo_full), .o_fifo_empty(o_fifo_empty)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [8:0] data;
    logic [2:0] size;
    logic [2:0] par;
    logic       stop2;
  } frame_t;

  frame_t sb_q[$];
  int     n_vec = 0;
  int     n_err = 0;
  int     stick_period = 1;
  int     stick_cnt = 0;
  bit     mon_busy = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int nbits_of(input logic [2:0] s);
    case (s)
      3'd0: return 5;
      3'd1: return 6;
      3'd2: return 7;
      3'd4: return 9;
      default: return 8;
    endcase
  endfunction

  function automatic bit par_en_of(input logic [2:0] p);
    return (p >= 3'd1 && p <= 3'd4);
  endfunction

  function automatic logic par_val_of(input frame_t f);
    int ones = 0;
    for (int i = 0; i < nbits_of(f.size); i++) ones += int'(f.data[i]);
    case (f.par)
      3'd1: return (ones % 2 == 0);
      3'd2: return (ones % 2 == 1);
      3'd3: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Tick generator: one pulse every stick_period cycles
  initial begin
    i_stick = 1'b0;
    forever begin
      @(posedge i_clk); #1;
      stick_cnt++;
      if (stick_cnt >= stick_period) stick_cnt = 0;
      i_stick = (stick_cnt == 0);
    end
  end

  task automatic receive_frame();
    frame_t     f;
    int         nb, total, ticks, cyc, idx;
    logic       bits [0:15];
    logic [8:0] got, exp_data;
    mon_busy = 1'b1;
    check("frame_expected", 32'(sb_q.size() != 0), 1);
    if (sb_q.size() == 0) begin
      mon_busy = 1'b0;
      return;
    end
    f     = sb_q.pop_front();
    nb    = nbits_of(f.size);
    total = 1 + nb + (par_en_of(f.par) ? 1 : 0) + (f.stop2 ? 2 : 1);
    ticks = 0;
    cyc   = 0;
    for (int i = 0; i < 16; i++) bits[i] = 1'bx;
    while (!o_done_tx && !i_rst && cyc < 5000) begin
      if (i_stick) begin
        ticks++;
        if ((ticks % OS) == OS / 2 && (ticks / OS) < 16) bits[ticks / OS] = o_data_tx;
      end
      @(negedge i_clk);
      cyc++;
    end
    if (i_rst) begin
      mon_busy = 1'b0;
      return;
    end
    check("done_seen", 32'(o_done_tx), 1);
    check("frame_ticks", 32'(ticks), 32'(OS * total));
    check("start_bit", 32'(bits[0]), 0);
    got = '0;
    exp_data = '0;
    for (int i = 0; i < nb; i++) begin
      got[i]      = bits[1 + i];
      exp_data[i] = f.data[i];
    end
    check("data_bits", 32'(got), 32'(exp_data));
    idx = 1 + nb;
    if (par_en_of(f.par)) begin
      check("parity_bit", 32'(bits[idx]), 32'(par_val_of(f)));
      idx++;
    end
    check("stop1_bit", 32'(bits[idx]), 1);
    if (f.stop2) check("stop2_bit", 32'(bits[idx + 1]), 1);
    @(negedge i_clk);
    check("done_pulse_width", 32'(o_done_tx), 0);
    check("line_after_done", 32'(o_data_tx), 1);
    mon_busy = 1'b0;
  endtask

  initial begin : line_monitor
    logic prev;
    prev = 1'b1;
    forever begin
      @(negedge i_clk);
      if (!i_rst && prev && !o_data_tx && !i_break) receive_frame();
      prev = o_data_tx;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge i_clk); #1;
    end
  endtask

  task automatic push_word(input logic [8:0] d, output bit acc);
    i_valid = 1'b1;
    i_data  = d;
    acc     = o_ready;
    if (acc) sb_q.push_back('{data: d, size: i_size_frame, par: i_parity, stop2: i_stop_bit});
    tick();
    i_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int cyc = 0;
    while (!(o_fifo_empty && !o_busy && !mon_busy && sb_q.size() == 0) && cyc < 20000) begin
      tick();
      cyc++;
    end
    check(tag, 32'(cyc < 20000), 1);
    tick(4);
  endtask

  task automatic measure_high(output int hi);
    int cyc = 0;
    hi = 0;
    @(negedge i_clk);
    while (!o_data_tx && cyc < 100) begin
      @(negedge i_clk);
      cyc++;
    end
    while (o_data_tx && cyc < 1000) begin
      hi++;
      @(negedge i_clk);
      cyc++;
    end
    @(posedge i_clk); #1;
  endtask

  initial begin : watchdog
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    bit acc;
    int hi, lows, cyc;
    i_rst = 1'b1; i_valid = 1'b0; i_data = '0; i_break = 1'b0;
    i_size_frame = 3'd3; i_parity = 3'd0; i_stop_bit = 1'b0;
    tick(3);
    check("rst_line", 32'(o_data_tx), 1);
    check("rst_done", 32'(o_done_tx), 0);
    check("rst_busy", 32'(o_busy), 0);
    check("rst_count", 32'(o_fifo_count), 0);
    check("rst_empty", 32'(o_fifo_empty), 1);
    check("rst_full", 32'(o_fifo_full), 0);
    check("rst_ready", 32'(o_ready), 1);
    i_rst = 1'b0;
    tick(2);

    // 8N1 0xA5, tick every cycle; first cycle after push must not pop yet
    push_word(9'h0A5, acc);
    check("nobypass_count", 32'(o_fifo_count), 1);
    check("nobypass_busy", 32'(o_busy), 0);
    check("nobypass_line", 32'(o_data_tx), 1);
    tick();
    check("pop_count", 32'(o_fifo_count), 0);
    check("pop_busy", 32'(o_busy), 1);
    check("pop_line", 32'(o_data_tx), 0);
    wait_idle("idle_8n1");
    check("count_after_8n1", 32'(o_fifo_count), 0);

    // Formats with a sparse tick
    stick_period = 3;
    i_size_frame = 3'd0; i_parity = 3'd1; i_stop_bit = 1'b1;
    push_word(9'h1F3, acc);
    wait_idle("idle_5o2");
    i_parity = 3'd3;
    push_word(9'h1F3, acc);
    wait_idle("idle_5m2");
    i_size_frame = 3'd4; i_parity = 3'd2; i_stop_bit = 1'b0;
    push_word(9'h155, acc);
    wait_idle("idle_9e1");
    i_size_frame = 3'd7; i_parity = 3'd7;
    push_word(9'h1C3, acc);
    wait_idle("idle_rsvd_codes");
    stick_period = 1;

    // Break while filling the FIFO
    i_size_frame = 3'd3; i_parity = 3'd0; i_stop_bit = 1'b0;
    i_break = 1'b1;
    tick(3);
    check("break_line", 32'(o_data_tx), 0);
    check("break_busy", 32'(o_busy), 1);
    for (int i = 0; i < 9; i++) begin
      push_word(9'(i * 37 + 3), acc);
      check(i < 8 ? "push_accepted" : "push_refused", 32'(acc), i < 8 ? 1 : 0);
    end
    check("full_count", 32'(o_fifo_count), 8);
    check("full_flag", 32'(o_fifo_full), 1);
    check("full_ready", 32'(o_ready), 0);
    check("full_line", 32'(o_data_tx), 0);
    i_break = 1'b0;
    measure_high(hi);
    check("brk_end_high", 32'(hi), 17);
    wait_idle("idle_drain");
    check("count_after_drain", 32'(o_fifo_count), 0);

    // Config change during DATA bit 3 applies only to the next frame
    push_word(9'h13C, acc);
    tick(70);
    i_size_frame = 3'd0; i_parity = 3'd2;
    check("midframe_busy", 32'(o_busy), 1);
    push_word(9'h0B6, acc);
    wait_idle("idle_cfg_change");
    i_size_frame = 3'd3; i_parity = 3'd0;

    // Break during DATA bit 2: frame completes first
    push_word(9'h05A, acc);
    tick(50);
    i_break = 1'b1;
    cyc = 0;
    while (!o_done_tx && cyc < 1000) begin
      tick();
      cyc++;
    end
    check("done_before_break", 32'(o_done_tx), 1);
    tick(2);
    check("break_after_frame", 32'(o_data_tx), 0);
    tick(20);
    check("break_held", 32'(o_data_tx), 0);
    push_word(9'h0E1, acc);
    check("push_during_break", 32'(acc), 1);
    i_break = 1'b0;
    measure_high(hi);
    check("brk_end_high2", 32'(hi), 17);
    wait_idle("idle_break_mid");

    // Asynchronous reset during DATA bit 4 with words queued
    push_word(9'h111, acc);
    push_word(9'h0F0, acc);
    push_word(9'h022, acc);
    tick(84);
    check("pre_rst_line_busy", 32'(o_busy), 1);
    #2 i_rst = 1'b1;
    #1;
    check("arst_line", 32'(o_data_tx), 1);
    check("arst_count", 32'(o_fifo_count), 0);
    check("arst_ready", 32'(o_ready), 1);
    check("arst_busy", 32'(o_busy), 0);
    check("arst_empty", 32'(o_fifo_empty), 1);
    sb_q.delete();
    tick(3);
    i_rst = 1'b0;
    lows = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (!o_data_tx || o_busy) lows++;
    end
    check("no_frame_after_reset", 32'(lows), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Next-generation UART transmitter with an internal transmit FIFO and a valid/ready push interface. Frame format is run-time configurable: 5–9 data bits, none/odd/even/mark/space parity, and 1 or 2 stop bits. Frame configuration is latched per frame, and break generation is supported. It sits between the bus-side register block and the TX pin, and is paced by the shared baud-oversampling tick i_stick.

Parameters:
DATA_MAX, 9, width of i_data and FIFO entries; frames use the low N bits.
OVER_SAMPLING, 16, i_stick ticks per bit period; must be ≥2.
FIFO_DEPTH, 8, FIFO entries; power of two, ≥2.

Ports:
i_clk  in  1  single clock for the whole block.
i_rst  in  1  reset; asynchronous, active-high.
i_stick  in  1  oversampling tick, one-cycle pulses.
i_valid  in  1  push request.
o_ready  out  1  FIFO can accept data (= !o_fifo_full).
i_data  in  DATA_MAX  word to push.
i_size_frame  in  3  000=5, 001=6, 010=7, 011=8, 100=9 bits; 101–111 = 8 bits.
i_parity  in  3  000 none, 001 odd, 010 even, 011 mark (1), 100 space (0); others = none.
i_stop_bit  in  1  0 = 1 stop bit, 1 = 2 stop bits.
i_break  in  1  level request to hold the line low.
o_data_tx  out  1  serial line, registered.
o_done_tx  out  1  one-cycle pulse per completed frame.
o_busy  out  1  state != IDLE.
o_fifo_count  out  $clog2(FIFO_DEPTH)+1  current occupancy.
o_fifo_full / o_fifo_empty  out  1 each  occupancy flags.

Behaviour:
- Interface: one clock (i_clk); reset (i_rst) is asynchronous and active-high.
- Reset values:
  - o_data_tx=1, o_done_tx=0, o_busy=0.
  - FIFO flushed: count=0, empty=1, full=0, o_ready=1.
  - State IDLE; tick counter and bit index cleared.
  - Reset mid-frame aborts the frame and the line goes high immediately.
- FIFO:
  - Push occurs when i_valid & o_ready.
  - Pop occurs only from IDLE.
  - Simultaneous push and pop leaves count unchanged.
  - No bypass: a word pushed into an empty FIFO is popped no earlier than the next cycle.
  - Push while full is impossible because o_ready=0.
- Bit timing:
  - Tick counter width is $clog2(OVER_SAMPLING).
  - A bit ends on the i_stick cycle where counter==OVER_SAMPLING-1; each bit lasts exactly OVER_SAMPLING ticks.
  - The counter holds when i_stick=0.
- o_data_tx is a flop updated on the same edge as the state transition: it carries the value of the state being entered.
- FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2, DONE, BREAK, BRK_END.
  - IDLE: if i_break=1, go to BREAK (break has priority). Else if the FIFO is not empty: pop into the shift register; latch size, parity mode and stop count; go to START with line 0.
  - START: after 1 bit, go to DATA. Bit 0 is driven.
  - DATA: bits are sent LSB first, index 0..N-1. After bit N-1, go to PARITY if parity is enabled, else STOP1.
  - PARITY: bit value is as follows.
    - odd = ~^(active N bits).
    - even = ^(active N bits).
    - mark = 1, space = 0.
    - Bits above N are excluded from the parity calculation.
  - STOP1 / STOP2: line 1. STOP1 goes to STOP2 if 2 stop bits were latched, else to DONE.
  - DONE: exactly 1 cycle; o_done_tx=1 and line 1; then IDLE.
  - BREAK: line 0 while i_break=1. On deassert, go to BRK_END.
  - BRK_END: line 1 for one full bit period, then IDLE.
- Config inputs are ignored except at pop; changes mid-frame do not affect the current frame.
- i_break asserted mid-frame: the current frame completes including its stop bits, then BREAK is entered.
- Back-to-back frames: the next start bit begins 2 cycles after the last stop bit ends (DONE, then IDLE pop).

Test Plan:
1. OVER_SAMPLING=16, i_stick=1 every cycle, 8N1, push 0xA5 -> line shows 0,1,0,1,0,0,1,0,1,1, each bit 16 cycles. o_done_tx pulses once on the cycle after the stop bit; count returns to 0.
2. 5-bit, odd parity, 2 stop bits, push 9'h1F3 -> data bits 1,1,0,0,1, then parity 0, then 32 ticks high, then done. Repeat with mark parity -> parity bit 1.
3. Hold i_break=1 and push 9 words -> 8 are accepted, o_fifo_full=1, o_ready=0 on the 9th, count=8, line held 0. Release i_break -> 16 ticks high, then 8 frames in push order; count decrements to 0.
4. Change i_size_frame 011→000 and i_parity during DATA bit 3 -> the current frame still sends 8 bits and no parity. The next frame uses the new format.
5. Assert i_break during DATA bit 2 -> the frame completes through its stop bit, then the line is low while i_break=1. After release, ≥16 ticks high before the next start bit.
6. Assert i_rst during DATA bit 4 with 3 words queued -> o_data_tx=1 asynchronously, count=0, o_ready=1, o_busy=0. No frame starts after reset release.
